// File: rtl/remote_update_sequencer.sv
// remote_update_sequencer
// Loads the watchdog and boot-address parameters into a remote-update core
// through its parameter-write port, waits out each busy handshake (with
// timeout and bounded retry), then requests reconfiguration.
// Optional macro RU_READBACK_EN: read back the boot address after writing it
// and only reconfigure when it matches; a mismatch counts as a failed write.
// All outputs are registered decodes of the state held during the previous cycle.

module remote_update_sequencer #(
    parameter int                         NUM_IMAGES   = 2,
    parameter int                         SEL_W        = 1,
    parameter logic [NUM_IMAGES*24-1:0]   IMAGE_ADDRS  = {24'h160000, 24'h0B0000},
    parameter logic [23:0]                WDOG_VALUE   = 24'h000000,
    parameter int                         BUSY_TIMEOUT = 1024,
    parameter int                         MAX_RETRIES  = 2,
    parameter int                         AUTO_START   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] image_sel,
    input  logic             busy,
    input  logic [23:0]      data_in,
    output logic             write_param,
    output logic             read_param,
    output logic [2:0]       param,
    output logic [23:0]      data_out,
    output logic             reconfig,
    output logic             active,
    output logic             error
);

    localparam int              TO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
    localparam int              RT_W    = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

    localparam logic [2:0] P_WDOG = 3'b011;
    localparam logic [2:0] P_ADDR = 3'b100;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] WR_WDOG   = 4'd1;
    localparam logic [3:0] WAIT_HI_0 = 4'd2;
    localparam logic [3:0] WAIT_LO_0 = 4'd3;
    localparam logic [3:0] WR_ADDR   = 4'd4;
    localparam logic [3:0] WAIT_HI_1 = 4'd5;
    localparam logic [3:0] WAIT_LO_1 = 4'd6;
    localparam logic [3:0] RECONFIG  = 4'd7;
    localparam logic [3:0] ERROR     = 4'd8;
`ifdef RU_READBACK_EN
    localparam logic [3:0] RD_ADDR   = 4'd9;
    localparam logic [3:0] WAIT_HI_2 = 4'd10;
    localparam logic [3:0] WAIT_LO_2 = 4'd11;
`endif

    logic [3:0]       state, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [TO_W-1:0]  to_cnt, cnt_d;
    logic [RT_W-1:0]  retries, ret_d;
    logic             pending, pend_d;
    logic [23:0]      addr;

    logic             waiting, hit, completes, fail;
    logic [3:0]       origin, adv;

`ifndef RU_READBACK_EN
    // Core read data has no consumer without readback.
    logic unused_data_in;
    assign unused_data_in = ^data_in;
`endif

    // Boot address for the latched image; out-of-range indices never reach a write.
    always_comb begin
        addr = '0;
        for (int i = 0; i < NUM_IMAGES; i++) begin
            if (32'(sel_q) == i) addr = IMAGE_ADDRS[24*i +: 24];
        end
    end

    // Next-state, handshake timeout and retry bookkeeping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state;
        sel_d     = sel_q;
        cnt_d     = to_cnt;
        ret_d     = retries;
        pend_d    = pending;
        waiting   = 1'b0;
        hit       = 1'b0;
        completes = 1'b0;
        fail      = 1'b0;
        origin    = IDLE;
        adv       = IDLE;

        case (state)
            IDLE, ERROR: begin
                if ((start || pending) && !busy) begin
                    sel_d   = image_sel;
                    pend_d  = 1'b0;
                    ret_d   = '0;
                    state_d = (32'(image_sel) >= NUM_IMAGES) ? ERROR : WR_WDOG;
                end
            end
            WR_WDOG:   state_d = WAIT_HI_0;
            WAIT_HI_0: begin waiting = 1'b1; hit = busy;  origin = WR_WDOG; adv = WAIT_LO_0; end
            WAIT_LO_0: begin waiting = 1'b1; hit = !busy; origin = WR_WDOG; adv = WR_ADDR; completes = 1'b1; end
            WR_ADDR:   state_d = WAIT_HI_1;
            WAIT_HI_1: begin waiting = 1'b1; hit = busy;  origin = WR_ADDR; adv = WAIT_LO_1; end
`ifdef RU_READBACK_EN
            // The address write is only complete once the readback matches.
            WAIT_LO_1: begin waiting = 1'b1; hit = !busy; origin = WR_ADDR; adv = RD_ADDR; end
            RD_ADDR:   state_d = WAIT_HI_2;
            WAIT_HI_2: begin waiting = 1'b1; hit = busy;  origin = RD_ADDR; adv = WAIT_LO_2; end
            WAIT_LO_2: begin waiting = 1'b1; hit = !busy; origin = RD_ADDR; adv = RECONFIG; completes = 1'b1; end
`else
            WAIT_LO_1: begin waiting = 1'b1; hit = !busy; origin = WR_ADDR; adv = RECONFIG; completes = 1'b1; end
`endif
            RECONFIG:  state_d = RECONFIG;
            default:   state_d = IDLE;
        endcase

        if (waiting) begin
            if (hit) begin
                state_d = adv;
                if (completes) ret_d = '0;
            end else if (to_cnt == TO_LAST) begin
                fail = 1'b1;
            end else begin
                cnt_d = to_cnt + TO_W'(1);
            end
        end

`ifdef RU_READBACK_EN
        // Readback sampled on the cycle busy falls; a mismatch re-issues the address write.
        if (state == WAIT_LO_2 && !busy && data_in != addr) begin
            fail   = 1'b1;
            origin = WR_ADDR;
        end
`endif

        if (fail) begin
            if (retries < RT_MAX) begin
                ret_d   = retries + RT_W'(1);
                state_d = origin;
            end else begin
                state_d = ERROR;
            end
        end

        // Every state change restarts the wait budget for the state being entered.
        if (state_d != state) cnt_d = '0;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            to_cnt  <= '0;
            retries <= '0;
            pending <= (AUTO_START != 0);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
            state   <= state_d;
            sel_q   <= sel_d;
            to_cnt  <= cnt_d;
            retries <= ret_d;
            pending <= pend_d;
        end
    end

    // Registered output decode of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_param <= 1'b0;
            read_param  <= 1'b0;
            param       <= '0;
            data_out    <= '0;
            reconfig    <= 1'b0;
            active      <= 1'b0;
            error       <= 1'b0;
        end else begin
            write_param <= (state == WR_WDOG) || (state == WR_ADDR);
            param       <= (state == WR_WDOG) ? P_WDOG :
                           (state == WR_ADDR) ? P_ADDR : 3'b000;
            data_out    <= (state == WR_WDOG) ? WDOG_VALUE :
                           (state == WR_ADDR) ? addr : 24'h000000;
`ifdef RU_READBACK_EN
            read_param  <= (state == RD_ADDR);
            if (state == RD_ADDR) param <= P_ADDR;
`else
            read_param  <= 1'b0;
`endif
            reconfig    <= (state == RECONFIG);
            active      <= (state != IDLE) && (state != ERROR);
            error       <= (state == ERROR);
        end
    end

endmodule

// File: tb/tb_remote_update_sequencer.sv
// Self-checking bench for remote_update_sequencer.
// dut_a: default parameters (two images, auto-start, long timeout).
// dut_b: three images, BUSY_TIMEOUT=16, MAX_RETRIES=2, no auto-start.

module tb_remote_update_sequencer;

    typedef struct {
        logic        start;
        logic [1:0]  sel;
        logic        busy;
        logic [31:0] exp;   // {write_param, read_param, param, data_out, reconfig, active, error}
    } vec_t;

    typedef struct {
        logic [2:0]  p;
        logic [23:0] d;
        int          c;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic        rst_a, start_a, sel_a, resp_a, hold_a, en_a;
    logic [23:0] din_a;
    logic        busy_a;
    logic        wp_a, rp_a, rc_a, act_a, err_a;
    logic [2:0]  param_a;
    logic [23:0] dout_a;

    // dut_b signals
    logic        rst_b, start_b, resp_b, hold_b, en_b;
    logic [1:0]  sel_b;
    logic [23:0] din_b;
    logic        busy_b;
    logic        wp_b, rp_b, rc_b, act_b, err_b;
    logic [2:0]  param_b;
    logic [23:0] dout_b;

    assign busy_a = resp_a | hold_a;
    assign busy_b = resp_b | hold_b;

    remote_update_sequencer dut_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .image_sel(sel_a), .busy(busy_a),
        .data_in(din_a), .write_param(wp_a), .read_param(rp_a), .param(param_a),
        .data_out(dout_a), .reconfig(rc_a), .active(act_a), .error(err_a)
    );

    remote_update_sequencer #(
        .NUM_IMAGES(3), .SEL_W(2),
        .IMAGE_ADDRS({24'h200000, 24'h160000, 24'h0B0000}),
        .WDOG_VALUE(24'h000000), .BUSY_TIMEOUT(16), .MAX_RETRIES(2), .AUTO_START(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .image_sel(sel_b), .busy(busy_b),
        .data_in(din_b), .write_param(wp_b), .read_param(rp_b), .param(param_b),
        .data_out(dout_b), .reconfig(rc_b), .active(act_b), .error(err_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    wr_t wr_a[$];
    wr_t wr_b[$];
    int rd_a = 0;
    int rd_b = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [1:0] sl, input logic b,
                                input logic wp, input logic rp, input logic [2:0] p,
                                input logic [23:0] d, input logic rc, input logic ac,
                                input logic er);
        vec_t v;
        v.start = s; v.sel = sl; v.busy = b;
        v.exp = {wp, rp, p, d, rc, ac, er};
        return v;
    endfunction

    // Core model: one busy pulse a couple of cycles after each strobe.
    logic d0_a = 1'b0, d1_a = 1'b0, d0_b = 1'b0, d1_b = 1'b0;
    initial forever begin
        @(negedge clk);
        resp_a = en_a & d1_a; d1_a = d0_a; d0_a = wp_a | rp_a;
        resp_b = en_b & d1_b; d1_b = d0_b; d0_b = wp_b | rp_b;
    end

    // Strobe log, sampled just after each active edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (wp_a) wr_a.push_back('{param_a, dout_a, cyc});
        if (wp_b) wr_b.push_back('{param_b, dout_b, cyc});
        if (rp_a) rd_a++;
        if (rp_b) rd_b++;
    end

    function automatic logic [31:0] outs_b();
        return {wp_b, rp_b, param_b, dout_b, rc_b, act_b, err_b};
    endfunction

    function automatic logic [31:0] outs_a();
        return {wp_a, rp_a, param_a, dout_a, rc_a, act_a, err_a};
    endfunction

    initial begin
        rst_a = 1'b0; start_a = 1'b0; sel_a = 1'b1; hold_a = 1'b0; en_a = 1'b0; resp_a = 1'b0;
        rst_b = 1'b0; start_b = 1'b0; sel_b = 2'd0; hold_b = 1'b0; en_b = 1'b0; resp_b = 1'b0;
        din_a = 24'h160000;
        din_b = 24'h200000;

        // Best-case table for dut_b, image 2; one busy cycle per handshake.
        vecs.push_back(mk(1, 2, 0,  0, 0, 3'd0, 24'h000000, 0, 0, 0));
        vecs.push_back(mk(0, 2, 0,  1, 0, 3'd3, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 1,  0, 0, 3'd0, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 0,  0, 0, 3'd0, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 0,  1, 0, 3'd4, 24'h200000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 1,  0, 0, 3'd0, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 0,  0, 0, 3'd0, 24'h000000, 0, 1, 0));
`ifdef RU_READBACK_EN
        vecs.push_back(mk(0, 2, 0,  0, 1, 3'd4, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 1,  0, 0, 3'd0, 24'h000000, 0, 1, 0));
        vecs.push_back(mk(0, 2, 0,  0, 0, 3'd0, 24'h000000, 0, 1, 0));
`endif
        vecs.push_back(mk(0, 2, 0,  0, 0, 3'd0, 24'h000000, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0,  0, 0, 3'd0, 24'h000000, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 3'd0, 24'h000000, 1, 1, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_a", outs_a(), 32'h0);
        check("reset_outputs_b", outs_b(), 32'h0);

        // Auto-start after reset release, image 1.
        @(negedge clk);
        en_a = 1'b1;
        rst_a = 1'b1;
        for (int i = 0; i < 200 && !rc_a; i++) @(posedge clk);
        @(negedge clk);
        check("a_reconfig", 32'(rc_a), 32'd1);
        check("a_error", 32'(err_a), 32'd0);
        check("a_write_count", 32'(wr_a.size()), 32'd2);
        if (wr_a.size() >= 2) begin
            check("a_wdog_write", {5'd0, wr_a[0].p, wr_a[0].d}, {5'd0, 3'd3, 24'h000000});
            check("a_addr_write", {5'd0, wr_a[1].p, wr_a[1].d}, {5'd0, 3'd4, 24'h160000});
        end

        // busy held high across reset release delays the auto-start.
        rst_a = 1'b0;
        hold_a = 1'b1;
        wr_a.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        repeat (6) @(negedge clk);
        check("a_hold_idle_active", 32'(act_a), 32'd0);
        check("a_hold_no_strobe", 32'(wr_a.size()), 32'd0);
        hold_a = 1'b0;
        @(posedge clk);
        #1;
        check("a_hold_accept_cycle", 32'(wp_a), 32'd0);
        @(posedge clk);
        #1;
        check("a_hold_first_strobe", {28'd0, wp_a, param_a}, {28'd0, 1'b1, 3'd3});

        // dut_b: no auto-start, then the per-cycle table.
        @(negedge clk);
        rst_b = 1'b1;
        repeat (4) @(negedge clk);
        check("b_no_autostart", 32'(act_b), 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start_b = vecs[i].start;
            sel_b   = vecs[i].sel;
            hold_b  = vecs[i].busy;
            @(posedge clk);
            #1;
            check($sformatf("b_vec%0d", i), outs_b(), vecs[i].exp);
        end

        // Out-of-range image goes straight to ERROR without any write.
        @(negedge clk);
        rst_b = 1'b0; start_b = 1'b0; hold_b = 1'b0;
        wr_b.delete();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1; sel_b = 2'd3;
        @(negedge clk);
        start_b = 1'b0;
        @(posedge clk);
        #1;
        check("b_badsel_error", {30'd0, err_b, act_b}, {30'd0, 2'b10});
        repeat (5) @(negedge clk);
        check("b_badsel_no_write", 32'(wr_b.size()), 32'd0);

        // Restart from ERROR with image 0.
        en_b = 1'b1;
        din_b = 24'h0B0000;
        start_b = 1'b1; sel_b = 2'd0;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 200 && !rc_b; i++) @(posedge clk);
        @(negedge clk);
        check("b_restart_reconfig", 32'(rc_b), 32'd1);
        check("b_restart_error_cleared", 32'(err_b), 32'd0);
        check("b_restart_write_count", 32'(wr_b.size()), 32'd2);
        if (wr_b.size() >= 2)
            check("b_restart_addr", {5'd0, wr_b[1].p, wr_b[1].d}, {5'd0, 3'd4, 24'h0B0000});

        // Busy never rises: three watchdog writes 17 cycles apart, then ERROR.
        rst_b = 1'b0; en_b = 1'b0;
        wr_b.delete();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        start_b = 1'b1; sel_b = 2'd1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 120 && !err_b; i++) @(posedge clk);
        @(negedge clk);
        check("b_timeout_error", {30'd0, err_b, rc_b}, {30'd0, 2'b10});
        check("b_timeout_write_count", 32'(wr_b.size()), 32'd3);
        if (wr_b.size() >= 3) begin
            check("b_timeout_gap1", 32'(wr_b[1].c - wr_b[0].c), 32'd17);
            check("b_timeout_gap2", 32'(wr_b[2].c - wr_b[1].c), 32'd17);
            check("b_timeout_param", {29'd0, wr_b[2].p}, 32'd3);
        end

`ifdef RU_READBACK_EN
        // Readback mismatch: address write issued 1 + MAX_RETRIES times, then ERROR.
        @(negedge clk);
        rst_a = 1'b0;
        din_a = 24'h123456;
        wr_a.delete();
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 400 && !err_a; i++) @(posedge clk);
        @(negedge clk);
        begin
            int n_addr = 0;
            foreach (wr_a[k]) if (wr_a[k].p == 3'd4) n_addr++;
            check("rb_mismatch_addr_writes", 32'(n_addr), 32'd3);
        end
        check("rb_mismatch_error", {30'd0, err_a, rc_a}, {30'd0, 2'b10});
        rst_a = 1'b0;
        din_a = 24'h160000;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        for (int i = 0; i < 200 && !rc_a; i++) @(posedge clk);
        @(negedge clk);
        check("rb_match_reconfig", {30'd0, rc_a, err_a}, {30'd0, 2'b10});
`else
        check("no_read_strobes", 32'(rd_a + rd_b), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
